// File: rtl/multi_cycle_adder.sv
// Multi-cycle adder/subtractor.
// Each operation is processed as N = WIDTH/CHUNK slices, one slice per clock,
// with a single carry passed between slices. sum, c_out and overflow are
// written together once the last slice finishes. done pulses for one cycle
// at that point.
//
// Parameter constraints: WIDTH >= 2, CHUNK >= 1, and CHUNK must divide WIDTH.
// Nothing enforces these, so every instantiation has to respect them.
module multi_cycle_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow
);

   localparam int N     = WIDTH / CHUNK;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;        // latched first operand
   logic [WIDTH-1:0] r_b;        // latched second operand, already inverted for subtract
   logic [WIDTH-1:0] r_acc;      // result slices finished so far
   logic             r_carry;    // carry into the current slice
   logic [CNT_W-1:0] r_cnt;      // index of the slice being added

   logic [CHUNK:0]   w_chunk_sum;
   logic [WIDTH-1:0] w_result;
   logic             w_overflow;

   // Add the current slice and build the complete result that would be
   // committed if this is the last slice.
   // NOTE: every signal gets a default at the top of always_comb, so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      w_chunk_sum = {1'b0, r_a[r_cnt*CHUNK +: CHUNK]}
                  + {1'b0, r_b[r_cnt*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, r_carry};
      w_result    = r_acc;
      w_result[r_cnt*CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
      // Signed overflow: both addends have the same sign and the result has
      // the other sign. This is equal to carry-in XOR carry-out of the MSB.
      w_overflow  = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                    (w_result[WIDTH-1] != r_a[WIDTH-1]);
   end

   assign busy = (r_state == RUN);

   // Control FSM and datapath registers. The visible outputs change only
   // when the final slice commits.
   // NOTE: state registers use non-blocking assignment, so every register here sees the values from before the clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the operand, accumulator and carry registers are cleared on reset as well, so an aborted operation leaves nothing behind.
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_acc    <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         done     <= 1'b0;
         sum      <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= sub ? ~b : b;
                  // Subtract is a + ~b + 1, so the carry is forced to 1.
                  r_carry <= sub | c_in;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_acc[r_cnt*CHUNK +: CHUNK] <= w_chunk_sum[CHUNK-1:0];
               r_carry <= w_chunk_sum[CHUNK];
               r_cnt   <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST) begin
                  sum      <= w_result;
                  c_out    <= w_chunk_sum[CHUNK];
                  overflow <= w_overflow;
                  done     <= 1'b1;
                  r_cnt    <= '0;
                  r_state  <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Self-checking bench for multi_cycle_adder.
// Three instances are used: 16/4 (main), 4/1 (exhaustive) and 8/8 (one slice).
// For the main instance, a timeline model of the expected outputs is compared
// against the DUT on every falling edge.
module tb_multi_cycle_adder;

   localparam int N_MAIN = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmp_en = 1'b0;

   // Signals for the main instance (WIDTH=16, CHUNK=4).
   logic        start = 1'b0, sub = 1'b0, c_in = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic        busy, done, c_out, overflow;
   logic [15:0] sum;

   // Signals for the exhaustive instance (WIDTH=4, CHUNK=1).
   logic        s4_start = 1'b0, s4_sub = 1'b0, s4_c_in = 1'b0;
   logic [3:0]  s4_a = '0, s4_b = '0;
   logic        s4_busy, s4_done, s4_c_out, s4_overflow;
   logic [3:0]  s4_sum;

   // Signals for the single-slice instance (WIDTH=8, CHUNK=8).
   logic        s8_start = 1'b0, s8_sub = 1'b0, s8_c_in = 1'b0;
   logic [7:0]  s8_a = '0, s8_b = '0;
   logic        s8_busy, s8_done, s8_c_out, s8_overflow;
   logic [7:0]  s8_sum;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   multi_cycle_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
      .c_in(c_in), .busy(busy), .done(done), .sum(sum), .c_out(c_out),
      .overflow(overflow));

   multi_cycle_adder #(.WIDTH(4), .CHUNK(1)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(s4_start), .sub(s4_sub), .a(s4_a),
      .b(s4_b), .c_in(s4_c_in), .busy(s4_busy), .done(s4_done), .sum(s4_sum),
      .c_out(s4_c_out), .overflow(s4_overflow));

   multi_cycle_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(s8_start), .sub(s8_sub), .a(s8_a),
      .b(s8_b), .c_in(s8_c_in), .busy(s8_busy), .done(s8_done), .sum(s8_sum),
      .c_out(s8_c_out), .overflow(s8_overflow));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Arithmetic reference for a w-bit operation.
   // res holds {carry, sum}, where carry means "no borrow" for subtract.
   // ovf is set when the true signed result does not fit in w bits.
   function automatic void ref_op(input int w, input longint ia, input longint ib,
                                  input bit icin, input bit isub,
                                  output longint res, output bit ovf);
      longint modv, half, sa, sb, tv;
      modv = longint'(1) << w;
      half = modv / 2;
      sa   = (ia >= half) ? ia - modv : ia;
      sb   = (ib >= half) ? ib - modv : ib;
      if (isub) begin
         res = ((ia - ib) % modv + modv) % modv;
         if (ia >= ib) res = res + modv;
         tv = sa - sb;
      end else begin
         res = ia + ib + longint'(icin);
         tv  = sa + sb + longint'(icin);
      end
      ovf = (tv >= half) || (tv < -half);
   endfunction

   // Timeline model of the main instance.
   // It accepts a start only when idle, completes N_MAIN edges after
   // acceptance, and clears on reset.
   int          m_left = 0;
   logic        m_done = 1'b0, m_cout = 1'b0, m_ovf = 1'b0;
   logic [15:0] m_sum = '0;
   longint      p_res;
   bit          p_ovf;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_left = 0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_sum  = p_res[15:0];
               m_cout = p_res[16];
               m_ovf  = p_ovf;
               m_done = 1'b1;
            end
         end else if (start) begin
            ref_op(16, longint'(a), longint'(b), c_in, sub, p_res, p_ovf);
            m_left = N_MAIN;
         end
      end
   end

   // Compare the main DUT against the model on every falling edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("busy", busy, (m_left > 0));
         check("done", done, m_done);
         check("sum", sum, m_sum);
         check("c_out", c_out, m_cout);
         check("overflow", overflow, m_ovf);
      end
   end

   // Run one operation on the main DUT.
   // lat counts falling edges from the start edge until done is seen.
   // bcnt counts the falling edges on which busy was high.
   task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input bit icin,
                         input bit isub, output int lat, output int bcnt);
      @(negedge clk);
      a = ia; b = ib; c_in = icin; sub = isub; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      bcnt = busy ? 1 : 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
         if (busy) bcnt++;
      end
      check("op_done_seen", done, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, bcnt, dones, cyc, last, nd;
      longint res;
      bit ovf;

      // Reset state.
      #1 rst_n = 1'b0;
      #1 cmp_en = 1'b1;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_sum", sum, 16'h0);
      check("rst_c_out", c_out, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Carry out of the full width. This start is also the first one after
      // reset is released.
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, bcnt);
      check("ffff_sum", sum, 16'h0000);
      check("ffff_c_out", c_out, 1'b1);
      check("ffff_ovf", overflow, 1'b0);
      check("ffff_latency", lat, N_MAIN + 1);
      check("ffff_busy_cycles", bcnt, N_MAIN);

      // Signed overflow and subtract cases.
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, bcnt);
      check("7fff_sum", sum, 16'h8000);
      check("7fff_c_out", c_out, 1'b0);
      check("7fff_ovf", overflow, 1'b1);
      run_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat, bcnt);
      check("sub57_sum", sum, 16'hFFFE);
      check("sub57_c_out", c_out, 1'b0);
      check("sub57_ovf", overflow, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat, bcnt);
      check("sub8000_sum", sum, 16'h7FFF);
      check("sub8000_c_out", c_out, 1'b1);
      check("sub8000_ovf", overflow, 1'b1);
      run_op(16'h1234, 16'h1111, 1'b1, 1'b0, lat, bcnt);
      check("cin_sum", sum, 16'h2346);

      // A second start and operand changes during a run must be ignored.
      @(negedge clk);
      a = 16'h1234; b = 16'h1111; c_in = 1'b0; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; a = 16'($urandom); b = 16'($urandom);
      @(negedge clk);
      start = 1'b1; a = 16'hFFFF;
      @(negedge clk);
      start = 1'b0; b = 16'($urandom);
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) begin
            dones++;
            check("ignore_sum", sum, 16'h2345);
         end
      end
      check("ignore_done_count", dones, 1);

      // Back-to-back operations with start held high and new operands
      // every cycle.
      @(negedge clk);
      start = 1'b1; a = 16'($urandom); b = 16'($urandom);
      sub = 1'($urandom); c_in = 1'($urandom);
      cyc = 0; last = -1; nd = 0;
      repeat (30) begin
         @(negedge clk);
         cyc++;
         a = 16'($urandom); b = 16'($urandom);
         sub = 1'($urandom); c_in = 1'($urandom);
         if (done) begin
            if (last >= 0) check("b2b_gap", cyc - last, N_MAIN + 1);
            last = cyc;
            nd++;
         end
      end
      start = 1'b0;
      check("b2b_done_count", nd, 6);
      repeat (6) @(negedge clk);

      // Reset during the second RUN cycle.
      run_op(16'h1234, 16'h1111, 1'b0, 1'b0, lat, bcnt);
      @(negedge clk);
      a = 16'hABCD; b = 16'h1357; sub = 1'b0; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_sum", sum, 16'h0);
      check("abort_c_out", c_out, 1'b0);
      check("abort_ovf", overflow, 1'b0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      run_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, lat, bcnt);
      check("post_abort_sum", sum, 16'h1000);
      check("post_abort_c_out", c_out, 1'b0);

      // Random traffic. Some start pulses arrive while the DUT is busy.
      repeat (400) begin
         @(negedge clk);
         start = ($urandom % 3 == 0);
         a = 16'($urandom); b = 16'($urandom);
         sub = 1'($urandom); c_in = 1'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);

      // Exhaustive check of the 4-bit instance with CHUNK=1.
      for (int s = 0; s < 2; s++) begin
         for (int ci = 0; ci < 2; ci++) begin
            for (int v = 0; v < 256; v++) begin
               @(negedge clk);
               s4_a = 4'(v); s4_b = 4'(v >> 4); s4_c_in = 1'(ci); s4_sub = 1'(s);
               s4_start = 1'b1;
               @(negedge clk);
               s4_start = 1'b0;
               lat = 1;
               while (!s4_done && lat < 20) begin
                  @(negedge clk);
                  lat++;
               end
               check("w4_latency", lat, 5);
               ref_op(4, longint'(s4_a), longint'(s4_b), s4_c_in, s4_sub, res, ovf);
               check("w4_result", {s4_c_out, s4_sum}, res[4:0]);
               check("w4_overflow", s4_overflow, ovf);
            end
         end
      end

      // Single-slice instance (CHUNK equals WIDTH).
      repeat (20) begin
         @(negedge clk);
         s8_a = 8'($urandom); s8_b = 8'($urandom);
         s8_c_in = 1'($urandom); s8_sub = 1'($urandom);
         s8_start = 1'b1;
         @(negedge clk);
         s8_start = 1'b0;
         check("w8_busy", s8_busy, 1'b1);
         lat = 1;
         while (!s8_done && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         check("w8_latency", lat, 2);
         ref_op(8, longint'(s8_a), longint'(s8_b), s8_c_in, s8_sub, res, ovf);
         check("w8_result", {s8_c_out, s8_sum}, res[8:0]);
         check("w8_overflow", s8_overflow, ovf);
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
